// File: rtl/gbar_responder.sv
// Global-barrier responder: round-robin arbitration of per-core arrivals, per-ID arrival
// masks, and a registered one-cycle release broadcast when the requested core count is met.
module gbar_responder #(
   parameter int unsigned NUM_CORES    = 4,
   parameter int unsigned NUM_BARRIERS = 8,
   parameter int unsigned NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
   parameter int unsigned NC_WIDTH     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_CORES-1:0]          req_valid,
   input  logic [NUM_CORES*NB_WIDTH-1:0] req_id,
   input  logic [NUM_CORES*NC_WIDTH-1:0] req_size_m1,
   output logic [NUM_CORES-1:0]          req_ready,
   output logic                          rsp_valid,
   output logic [NB_WIDTH-1:0]           rsp_id,
   output logic                          busy,
   output logic                          dup_err
);

   localparam int unsigned CW = NC_WIDTH + 1;
   typedef logic [CW-1:0] cnt_t;

   logic [NB_WIDTH-1:0]  w_req_id [NUM_CORES];
   logic [NC_WIDTH-1:0]  w_req_sz [NUM_CORES];

   for (genvar c = 0; c < NUM_CORES; c++) begin : g_unpack
      assign w_req_id[c] = req_id[c*NB_WIDTH +: NB_WIDTH];
      assign w_req_sz[c] = req_size_m1[c*NC_WIDTH +: NC_WIDTH];
   end

   logic [NC_WIDTH-1:0]  r_rr_ptr;
   logic [NUM_CORES-1:0] r_masks [NUM_BARRIERS];

   logic                 w_fire;
   logic [NC_WIDTH-1:0]  w_gnt_idx;
   logic [NUM_CORES-1:0] w_gnt_oh;

   // Search from the rr pointer upward with wrap; first valid core wins.
   always_comb begin
      cnt_t w_pos;
      w_fire    = 1'b0;
      w_gnt_idx = '0;
      w_gnt_oh  = '0;
      w_pos     = '0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         w_pos = cnt_t'({1'b0, r_rr_ptr}) + cnt_t'(i);
         if (w_pos >= cnt_t'(NUM_CORES)) w_pos = w_pos - cnt_t'(NUM_CORES);
         if (!w_fire && req_valid[w_pos[NC_WIDTH-1:0]]) begin
            w_fire                         = 1'b1;
            w_gnt_idx                      = w_pos[NC_WIDTH-1:0];
            w_gnt_oh[w_pos[NC_WIDTH-1:0]] = 1'b1;
         end
      end
   end

   assign req_ready = w_gnt_oh;

   logic [NB_WIDTH-1:0]  w_id;
   logic [NC_WIDTH-1:0]  w_sz;
   logic [NUM_CORES-1:0] w_cur_mask;
   logic [NUM_CORES-1:0] w_new_mask;
   logic                 w_dup;
   logic                 w_done;
   cnt_t                 w_cnt;

   assign w_id       = w_req_id[w_gnt_idx];
   assign w_sz       = w_req_sz[w_gnt_idx];
   assign w_cur_mask = r_masks[w_id];
   assign w_new_mask = w_cur_mask | w_gnt_oh;
   assign w_dup      = w_fire && ((w_cur_mask & w_gnt_oh) != '0);

   always_comb begin
      w_cnt = '0;
      for (int unsigned c = 0; c < NUM_CORES; c++) begin
         w_cnt = w_cnt + cnt_t'(w_new_mask[c]);
      end
   end

   // Completing arrival's size is authoritative; >= tolerates smaller later sizes.
   assign w_done = w_fire && !w_dup && (w_cnt >= (cnt_t'(w_sz) + cnt_t'(1)));

   logic [NUM_CORES-1:0] w_masks_d [NUM_BARRIERS];
   logic                 w_any_d;
   logic [NC_WIDTH-1:0]  w_rr_d;

   always_comb begin
      for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
         w_masks_d[b] = r_masks[b];
      end
      if (w_fire && !w_dup) begin
         w_masks_d[w_id] = w_done ? '0 : w_new_mask;
      end
      w_any_d = 1'b0;
      for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
         w_any_d = w_any_d | (|w_masks_d[b]);
      end
   end

   assign w_rr_d = (w_gnt_idx == NC_WIDTH'(NUM_CORES - 1)) ? '0 : w_gnt_idx + NC_WIDTH'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rr_ptr  <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         busy      <= 1'b0;
         dup_err   <= 1'b0;
         for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
            r_masks[b] <= '0;
         end
      end else begin
         if (w_fire) r_rr_ptr <= w_rr_d;
         for (int unsigned b = 0; b < NUM_BARRIERS; b++) begin
            r_masks[b] <= w_masks_d[b];
         end
         rsp_valid <= w_done;
         if (w_done) rsp_id <= w_id;
         busy <= w_any_d;
         if (w_dup) dup_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_gbar_responder.sv
// Directed bench for gbar_responder: arbitration order, release timing, duplicates, reset.
module tb_gbar_responder;

   localparam int unsigned NC  = 4;
   localparam int unsigned NBW = 3;
   localparam int unsigned NCW = 2;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [NC-1:0]     req_valid;
   logic [NC*NBW-1:0] req_id;
   logic [NC*NCW-1:0] req_size_m1;
   logic [NC-1:0]     req_ready;
   logic              rsp_valid;
   logic [NBW-1:0]    rsp_id;
   logic              busy;
   logic              dup_err;

   logic [NBW-1:0]    t_id [NC];
   logic [NCW-1:0]    t_sz [NC];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   always_comb begin
      req_id      = '0;
      req_size_m1 = '0;
      for (int c = 0; c < NC; c++) begin
         req_id[c*NBW +: NBW]      = t_id[c];
         req_size_m1[c*NCW +: NCW] = t_sz[c];
      end
   end

   gbar_responder #(
      .NUM_CORES   (NC),
      .NUM_BARRIERS(8)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_id     (req_id),
      .req_size_m1(req_size_m1),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .busy       (busy),
      .dup_err    (dup_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_all(input logic [NBW-1:0] id, input logic [NCW-1:0] sz);
      for (int c = 0; c < NC; c++) begin
         t_id[c] = id;
         t_sz[c] = sz;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n   = 1'b0;
      req_valid = '0;
      set_all(3'd0, 2'd0);
      #12 reset_n = 1'b1;

      // 1. asynchronous reset pulse mid-cycle, idle afterwards
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1 chk("rst_async_busy", 32'(busy), 0);
      chk("rst_async_rsp", 32'(rsp_valid), 0);
      #1 reset_n = 1'b1;
      @(negedge clk);
      #1;
      chk("idle_rsp", 32'(rsp_valid), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_dup", 32'(dup_err), 0);
      chk("idle_ready", 32'(req_ready), 0);

      // 2. sequential arrivals id=2 sz=3
      set_all(3'd2, 2'd3);
      req_valid = 4'b0001;
      #1 chk("seq_c0_ready", 32'(req_ready), 32'b0001);
      @(negedge clk);
      chk("seq_c1_busy", 32'(busy), 1);
      chk("seq_c1_rsp", 32'(rsp_valid), 0);
      req_valid = 4'b0010;
      #1 chk("seq_c1_ready", 32'(req_ready), 32'b0010);
      @(negedge clk);
      chk("seq_c2_busy", 32'(busy), 1);
      chk("seq_c2_rsp", 32'(rsp_valid), 0);
      req_valid = 4'b0100;
      #1 chk("seq_c2_ready", 32'(req_ready), 32'b0100);
      @(negedge clk);
      chk("seq_c3_busy", 32'(busy), 1);
      chk("seq_c3_rsp", 32'(rsp_valid), 0);
      req_valid = 4'b1000;
      #1 chk("seq_c3_ready", 32'(req_ready), 32'b1000);
      @(negedge clk);
      req_valid = '0;
      chk("seq_c4_rsp", 32'(rsp_valid), 1);
      chk("seq_c4_id", 32'(rsp_id), 2);
      chk("seq_c4_busy", 32'(busy), 0);
      @(negedge clk);
      chk("seq_c5_rsp", 32'(rsp_valid), 0);

      // 3. simultaneous contention id=5 sz=3; granted cores drop their request
      set_all(3'd5, 2'd3);
      req_valid = 4'b1111;
      #1 chk("cont_c0_ready", 32'(req_ready), 32'b0001);
      @(negedge clk);
      req_valid = 4'b1110;
      #1 chk("cont_c1_ready", 32'(req_ready), 32'b0010);
      @(negedge clk);
      req_valid = 4'b1100;
      #1 chk("cont_c2_ready", 32'(req_ready), 32'b0100);
      @(negedge clk);
      chk("cont_c3_rsp", 32'(rsp_valid), 0);
      req_valid = 4'b1000;
      #1 chk("cont_c3_ready", 32'(req_ready), 32'b1000);
      @(negedge clk);
      chk("cont_c4_rsp", 32'(rsp_valid), 1);
      chk("cont_c4_id", 32'(rsp_id), 5);
      chk("cont_c4_busy", 32'(busy), 0);
      set_all(3'd5, 2'd0);
      req_valid = 4'b0100;
      #1 chk("single_ready", 32'(req_ready), 32'b0100);
      @(negedge clk);
      req_valid = '0;
      chk("single_rsp", 32'(rsp_valid), 1);
      chk("single_id", 32'(rsp_id), 5);
      chk("single_busy", 32'(busy), 0);
      @(negedge clk);
      chk("single_rsp_off", 32'(rsp_valid), 0);

      // 4. interleaved IDs, rr pointer now 3
      set_all(3'd0, 2'd1);
      t_id[0] = 3'd1;
      req_valid = 4'b0001;
      #1 chk("il_c0_ready", 32'(req_ready), 32'b0001);
      @(negedge clk);
      t_id[1] = 3'd3;
      req_valid = 4'b0010;
      @(negedge clk);
      t_id[1] = 3'd1;
      req_valid = 4'b0010;
      #1 chk("il_c2_ready", 32'(req_ready), 32'b0010);
      @(negedge clk);
      chk("il_c3_rsp", 32'(rsp_valid), 1);
      chk("il_c3_id", 32'(rsp_id), 1);
      chk("il_c3_busy", 32'(busy), 1);
      t_id[0] = 3'd3;
      req_valid = 4'b0001;
      @(negedge clk);
      req_valid = '0;
      chk("il_c4_rsp", 32'(rsp_valid), 1);
      chk("il_c4_id", 32'(rsp_id), 3);
      chk("il_c4_busy", 32'(busy), 0);
      @(negedge clk);
      chk("il_c5_rsp", 32'(rsp_valid), 0);

      // 5. duplicate arrival: core1 id0 sz3 twice
      set_all(3'd0, 2'd3);
      req_valid = 4'b0010;
      #1 chk("dup_first_ready", 32'(req_ready), 32'b0010);
      @(negedge clk);
      chk("dup_mid_err", 32'(dup_err), 0);
      #1 chk("dup_second_ready", 32'(req_ready), 32'b0010);
      @(negedge clk);
      req_valid = '0;
      chk("dup_err_set", 32'(dup_err), 1);
      chk("dup_rsp", 32'(rsp_valid), 0);
      chk("dup_busy", 32'(busy), 1);
      chk("dup_mask0", 32'(dut.r_masks[0]), 32'b0010);
      @(negedge clk);
      chk("dup_err_sticky", 32'(dup_err), 1);
      chk("dup_rsp_after", 32'(rsp_valid), 0);

      // 6. reset in the middle of a barrier at id4
      set_all(3'd4, 2'd3);
      req_valid = 4'b0001;
      @(negedge clk);
      req_valid = 4'b0010;
      @(negedge clk);
      req_valid = '0;
      chk("mid_busy_pre", 32'(busy), 1);
      #2 reset_n = 1'b0;
      #1 chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_dup", 32'(dup_err), 0);
      #1 reset_n = 1'b1;
      @(negedge clk);
      req_valid = 4'b0100;
      #1 chk("mid_c2_ready", 32'(req_ready), 32'b0100);
      @(negedge clk);
      req_valid = 4'b1000;
      #1 chk("mid_c3_ready", 32'(req_ready), 32'b1000);
      @(negedge clk);
      req_valid = '0;
      chk("mid_busy", 32'(busy), 1);
      chk("mid_rsp", 32'(rsp_valid), 0);
      chk("mid_mask4", 32'(dut.r_masks[4]), 32'b1100);
      @(negedge clk);
      chk("mid_busy_hold", 32'(busy), 1);
      chk("mid_rsp_hold", 32'(rsp_valid), 0);
      chk("mid_dup", 32'(dup_err), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
